// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, parity modes and frame-timing helpers.
// Used by the transmitter now and intended for the matching receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef struct packed {
        logic [1:0] par;
        logic       two_stop;
    } uart_cfg_t;

    function automatic logic [1:0] par_mode(input logic par_en, input logic par_odd);
        if (!par_en) return PAR_NONE;
        return par_odd ? PAR_ODD : PAR_EVEN;
    endfunction

    function automatic int unsigned frame_cycles(input int unsigned clks_per_bit,
                                                 input int unsigned data_bits,
                                                 input logic [1:0]  par,
                                                 input logic        two_stop);
        int unsigned bits;
        bits = 2 + data_bits + ((par != PAR_NONE) ? 1 : 0) + (two_stop ? 1 : 0);
        return bits * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, pulses bit_tick on the last count.
// Held at zero when disabled or cleared.
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic clk,
    input  logic en,
    input  logic clr,
    output logic bit_tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign bit_tick = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en || bit_tick) cnt_d = '0;
        else                        cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with per-frame parity/stop configuration and a one-word holding
// register so consecutive frames are sent with no idle gap.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 data_valid,
    output logic                 in_ready,
    input  logic                 par_en,
    input  logic                 par_odd,
    input  logic                 two_stop,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
    uart_cfg_t            hold_cfg_q, hold_cfg_d;
    logic                 hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    uart_cfg_t            cfg_q, cfg_d;
    logic                 par_bit_q, par_bit_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tx_q, tx_d;
    logic                 tx_done_q, tx_done_d;
    logic                 load;
    logic                 bit_tick;

    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .en       (state_q != ST_IDLE),
        .clr      (rst),
        .bit_tick (bit_tick)
    );

    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_cfg_d  = hold_cfg_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        cfg_d       = cfg_q;
        par_bit_d   = par_bit_q;
        bit_idx_d   = bit_idx_q;
        stop_cnt_d  = stop_cnt_q;
        tx_done_d   = 1'b0;
        load        = 1'b0;

        unique case (state_q)
            ST_IDLE: if (hold_full_q) load = 1'b1;
            ST_START: if (bit_tick) state_d = ST_DATA;
            ST_DATA: if (bit_tick) begin
                shift_d = shift_q >> 1;
                if (bit_idx_q == IDX_W'(DATA_BITS - 1))
                    state_d = (cfg_q.par != PAR_NONE) ? ST_PARITY : ST_STOP;
                else
                    bit_idx_d = bit_idx_q + 1'b1;
            end
            ST_PARITY: if (bit_tick) state_d = ST_STOP;
            ST_STOP: if (bit_tick) begin
                if (stop_cnt_q || !cfg_q.two_stop) begin
                    tx_done_d = 1'b1;
                    if (hold_full_q) load = 1'b1;
                    else             state_d = ST_IDLE;
                end else begin
                    stop_cnt_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Load and accept are mutually exclusive: load needs a full holding register, accept an empty one.
        if (load) begin
            state_d     = ST_START;
            shift_d     = hold_data_q;
            cfg_d       = hold_cfg_q;
            par_bit_d   = (hold_cfg_q.par == PAR_ODD) ? ~^hold_data_q : ^hold_data_q;
            bit_idx_d   = '0;
            stop_cnt_d  = 1'b0;
            hold_full_d = 1'b0;
        end
        if (data_valid && !hold_full_q) begin
            hold_data_d = data_in;
            hold_cfg_d  = '{par: par_mode(par_en, par_odd), two_stop: two_stop};
            hold_full_d = 1'b1;
        end
    end

    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_bit_d;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hold_data_q <= '0;
            hold_cfg_q  <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            cfg_q       <= '0;
            par_bit_q   <= 1'b0;
            bit_idx_q   <= '0;
            stop_cnt_q  <= 1'b0;
            tx_q        <= 1'b1;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_cfg_q  <= hold_cfg_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            cfg_q       <= cfg_d;
            par_bit_q   <= par_bit_d;
            bit_idx_q   <= bit_idx_d;
            stop_cnt_q  <= stop_cnt_d;
            tx_q        <= tx_d;
            tx_done_q   <= tx_done_d;
        end
    end

    assign in_ready = !hold_full_q;
    assign busy     = (state_q != ST_IDLE);
    assign tx       = tx_q;
    assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg (CLKS_PER_BIT=4, DATA_BITS=8): per-cycle line-level
// reference model plus table-driven frame vectors and hand-written corner sequences.
module tb_uart_tx_cfg;

    localparam int unsigned CPB = 4;
    localparam int unsigned DB  = 8;

    logic          clk;
    logic          rst;
    logic [DB-1:0] data_in;
    logic          data_valid;
    logic          in_ready;
    logic          par_en, par_odd, two_stop;
    logic          tx, busy, tx_done;

    int tests;
    int fails;

    uart_tx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .in_ready   (in_ready),
        .par_en     (par_en),
        .par_odd    (par_odd),
        .two_stop   (two_stop),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the line as a queue of per-cycle samples, one frame expanded at a time.
    bit          line_q[$];
    bit          m_hold_full;
    logic [7:0]  m_hd;
    bit          m_hpe, m_hpo, m_hts;
    bit          m_done;

    function automatic void push_frame(input logic [7:0] d, input bit pe, input bit po, input bit ts);
        bit bits[$];
        int ones;
        ones = $countones(d);
        bits.push_back(1'b0);
        for (int i = 0; i < int'(DB); i++) bits.push_back(d[i]);
        if (pe) bits.push_back(po ? (ones % 2 == 0) : (ones % 2 == 1));
        bits.push_back(1'b1);
        if (ts) bits.push_back(1'b1);
        foreach (bits[b]) for (int c = 0; c < int'(CPB); c++) line_q.push_back(bits[b]);
    endfunction

    always @(posedge clk) begin
        bit acc, last;
        acc = data_valid && !m_hold_full;
        if (rst) begin
            line_q.delete();
            m_hold_full = 1'b0;
            m_done = 1'b0;
        end else begin
            last = (line_q.size() == 1);
            if (line_q.size() > 0) void'(line_q.pop_front());
            m_done = last;
            if (m_hold_full && line_q.size() == 0) begin
                push_frame(m_hd, m_hpe, m_hpo, m_hts);
                m_hold_full = 1'b0;
            end
            if (acc) begin
                m_hd = data_in; m_hpe = par_en; m_hpo = par_odd; m_hts = two_stop;
                m_hold_full = 1'b1;
            end
        end
        #1;
        check("model{tx,busy,in_ready,tx_done}", {28'd0, tx, busy, in_ready, tx_done},
              {28'd0, (line_q.size() > 0) ? line_q[0] : 1'b1, line_q.size() != 0, !m_hold_full, m_done});
    end

    typedef struct {
        logic [7:0]  data;
        bit          pe, po, ts, flip;
        int unsigned len;
        bit          par;
    } vec_t;

    vec_t vecs[9];

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy && in_ready) return;
        end
        check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    // Offers a word and returns on the negedge after the accepting edge.
    task automatic offer(input logic [7:0] d, input bit pe, input bit po, input bit ts);
        @(negedge clk);
        data_in = d; par_en = pe; par_odd = po; two_stop = ts; data_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (in_ready) begin
                @(negedge clk);
                data_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        data_valid = 1'b0;
        check("offer_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        bit          s[$];
        bit          got_done;
        logic [7:0]  dec;
        wait_idle();
        offer(v.data, v.pe, v.po, v.ts);
        if (v.flip) begin
            par_en = ~v.pe; two_stop = ~v.ts; par_odd = ~v.po;
        end
        got_done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (tx_done) begin got_done = 1'b1; break; end
            s.push_back(tx);
        end
        check({tag, "_done_seen"}, {31'd0, got_done}, 32'd1);
        check({tag, "_len"}, s.size(), v.len);
        check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        if (s.size() >= v.len && v.len > 0) begin
            for (int i = 0; i < int'(DB); i++) dec[i] = s[(1 + i) * CPB + 1];
            check({tag, "_start"}, {31'd0, s[1]}, 32'd0);
            check({tag, "_data"}, {24'd0, dec}, {24'd0, v.data});
            if (v.pe) check({tag, "_parity"}, {31'd0, s[(1 + DB) * CPB + 1]}, {31'd0, v.par});
            check({tag, "_stop"}, {31'd0, s[(1 + DB + (v.pe ? 1 : 0)) * CPB + 1]}, 32'd1);
        end
        @(negedge clk);
    endtask

    task automatic seq_back_to_back();
        int gap;
        bit seen;
        wait_idle();
        offer(8'h55, 1'b0, 1'b0, 1'b0);
        data_in = 8'hF0; par_en = 1'b0; par_odd = 1'b0; two_stop = 1'b0; data_valid = 1'b1;
        check("b2b_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("b2b_in_ready_after_load", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        data_valid = 1'b0;
        check("b2b_in_ready_second_held", {31'd0, in_ready}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (tx_done) begin seen = 1'b1; break; end
        end
        check("b2b_first_done", {31'd0, seen}, 32'd1);
        check("b2b_no_gap_tx", {31'd0, tx}, 32'd0);
        check("b2b_no_gap_busy", {31'd0, busy}, 32'd1);
        check("b2b_in_ready_after_second_load", {31'd0, in_ready}, 32'd1);
        gap = 0; seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            gap++;
            if (tx_done) begin seen = 1'b1; break; end
        end
        check("b2b_second_done", {31'd0, seen}, 32'd1);
        check("b2b_second_len", gap, 40);
        @(negedge clk);
    endtask

    task automatic seq_reset_mid_frame();
        int dones;
        vec_t v;
        wait_idle();
        offer(8'hA5, 1'b0, 1'b0, 1'b0);
        repeat (18) @(negedge clk);
        check("rst_pre_busy", {31'd0, busy}, 32'd1);
        check("rst_pre_bit3", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_outputs", {28'd0, tx, busy, in_ready, tx_done}, 32'b1010);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (tx_done) dones++;
        end
        check("rst_no_done_after_abort", dones, 0);
        v = '{data: 8'hA5, pe: 1'b0, po: 1'b0, ts: 1'b0, flip: 1'b0, len: 40, par: 1'b0};
        run_vec(v, "rst_fresh");
    endtask

    task automatic seq_held_valid();
        int dones;
        wait_idle();
        offer(8'h3A, 1'b0, 1'b0, 1'b0);
        data_in = 8'hC6; par_en = 1'b1; par_odd = 1'b0; two_stop = 1'b0; data_valid = 1'b1;
        repeat (32) @(negedge clk);
        check("held_in_ready_low", {31'd0, in_ready}, 32'd0);
        data_valid = 1'b0;
        dones = 0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk); #1;
            if (tx_done) dones++;
        end
        check("held_frame_count", dones, 2);
        check("held_idle_after", {30'd0, busy, in_ready}, 32'b01);
        @(negedge clk);
    endtask

    task automatic seq_random();
        for (int n = 0; n < 30; n++) begin
            int gap;
            gap = $urandom_range(0, 50);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                data_in = 8'($urandom);
                par_en = 1'($urandom); par_odd = 1'($urandom); two_stop = 1'($urandom);
                if ($urandom_range(0, 199) == 0) rst = 1'b1;
                else rst = 1'b0;
            end
            @(negedge clk);
            rst = 1'b0;
            offer(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        wait_idle();
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1; data_valid = 1'b0; data_in = '0;
        par_en = 1'b0; par_odd = 1'b0; two_stop = 1'b0;
        line_q.delete(); m_hold_full = 1'b0; m_done = 1'b0;
        m_hd = '0; m_hpe = 1'b0; m_hpo = 1'b0; m_hts = 1'b0;

        vecs[0] = '{data: 8'hA5, pe: 0, po: 0, ts: 0, flip: 0, len: 40, par: 0};
        vecs[1] = '{data: 8'h07, pe: 1, po: 0, ts: 0, flip: 0, len: 44, par: 1};
        vecs[2] = '{data: 8'h07, pe: 1, po: 1, ts: 0, flip: 0, len: 44, par: 0};
        vecs[3] = '{data: 8'h07, pe: 1, po: 0, ts: 1, flip: 0, len: 48, par: 1};
        vecs[4] = '{data: 8'h00, pe: 1, po: 1, ts: 1, flip: 0, len: 48, par: 1};
        vecs[5] = '{data: 8'hFF, pe: 0, po: 0, ts: 1, flip: 0, len: 44, par: 0};
        vecs[6] = '{data: 8'h3C, pe: 0, po: 0, ts: 0, flip: 1, len: 40, par: 0};
        vecs[7] = '{data: 8'h3C, pe: 1, po: 1, ts: 0, flip: 0, len: 44, par: 1};
        vecs[8] = '{data: 8'h81, pe: 1, po: 0, ts: 1, flip: 0, len: 48, par: 0};

        repeat (3) @(negedge clk);
        check("reset_state", {28'd0, tx, busy, in_ready, tx_done}, 32'b1010);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));
        seq_back_to_back();
        seq_reset_mid_frame();
        seq_held_valid();
        seq_random();

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
